// File: rtl/serial_tx20.sv
// serial_tx20: parallel-in, serial-out transmitter.
// Takes one word through a valid/ready handshake and shifts it out with
// DIV clock cycles per bit. While bits are on sdo, frame is high, and
// bit_stb marks the last cycle of each bit period as the receiver's
// sample point. done pulses once after a word completes. All outputs are
// registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a word; in_ready high from the first edge out of reset
// ST_SHIFT | word on the line; div_cnt paces bits, bit_cnt counts bits sent
// ST_DONE  | one-cycle gap after the last bit with the done pulse high
module serial_tx20 #(
    parameter int WIDTH     = 20,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             sdo,
    output logic             frame,
    output logic             bit_stb,
    output logic             done
);

    // DIV=1 would need a zero-width counter; keep one bit that never leaves 0.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;

    logic             div_wrap;
    logic             last_bit;
    logic [DW-1:0]    div_next;
    logic [WIDTH-1:0] shifted;
    logic             first_bit;
    logic             next_bit;

    // Bit-period pacing and shifter lookahead. sdo is registered, so the
    // next bit is taken from the position it will occupy after the shift.
    always_comb begin
        div_wrap  = (div_cnt == DIV_LAST);
        last_bit  = (bit_cnt == BIT_LAST);
        div_next  = div_wrap ? '0 : div_cnt + 1'b1;
        if (MSB_FIRST != 0) begin
            shifted   = {shreg[WIDTH-2:0], 1'b0};
            first_bit = in_data[WIDTH-1];
            next_bit  = shreg[WIDTH-2];
        end else begin
            shifted   = {1'b0, shreg[WIDTH-1:1]};
            first_bit = in_data[0];
            next_bit  = shreg[1];
        end
    end

    // Handshake, shifter, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            sdo      <= 1'b0;
            frame    <= 1'b0;
            bit_stb  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done    <= 1'b0;
                    bit_stb <= 1'b0;
                    if (in_ready && in_valid) begin
                        state    <= ST_SHIFT;
                        shreg    <= in_data;
                        in_ready <= 1'b0;
                        frame    <= 1'b1;
                        sdo      <= first_bit;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        // bit_stb is registered, so it is set one cycle ahead:
                        // with DIV=1 the first cycle is already a sample point.
                        bit_stb  <= (DIV_LAST == '0);
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        // Cancel wins over any bit or end-of-word step this edge.
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        frame    <= 1'b0;
                        sdo      <= 1'b0;
                        bit_stb  <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                    end else if (div_wrap && last_bit) begin
                        state   <= ST_DONE;
                        frame   <= 1'b0;
                        sdo     <= 1'b0;
                        bit_stb <= 1'b0;
                        done    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end else begin
                        div_cnt <= div_next;
                        bit_stb <= (div_next == DIV_LAST);
                        if (div_wrap) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shifted;
                            sdo     <= next_bit;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    frame    <= 1'b0;
                    sdo      <= 1'b0;
                    bit_stb  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx20.sv
// tb_serial_tx20: testbench for serial_tx20.
// Instance a uses the defaults (MSB first, DIV=4). Instance b is built LSB
// first with DIV=1. Expected serial bits are queued when a word is sent and
// checked against sdo at each bit_stb.
module tb_serial_tx20;

    logic        clk;
    logic        rst;
    logic [19:0] din_a, din_b;
    logic        vld_a, vld_b, abort_a, abort_b;
    logic        in_ready_a, sdo_a, frame_a, bit_stb_a, done_a;
    logic        in_ready_b, sdo_b, frame_b, bit_stb_b, done_b;

    int total = 0;
    int bad   = 0;

    logic q_a[$];
    logic q_b[$];
    int   frm_cnt[2];
    int   stb_cnt[2];
    int   dn_cnt[2];

    typedef struct {
        logic        sel;
        logic [19:0] data;
        logic [19:0] exp_serial;
        int          len;
    } vec_t;

    vec_t vecs[5];

    serial_tx20 #(.WIDTH(20), .DIV(4), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(vld_a),
        .in_ready(in_ready_a), .abort(abort_a), .sdo(sdo_a),
        .frame(frame_a), .bit_stb(bit_stb_a), .done(done_a)
    );

    serial_tx20 #(.WIDTH(20), .DIV(1), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vld_b),
        .in_ready(in_ready_b), .abort(abort_b), .sdo(sdo_b),
        .frame(frame_b), .bit_stb(bit_stb_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic g_rdy(input logic s); return s ? in_ready_b : in_ready_a; endfunction
    function automatic logic g_frm(input logic s); return s ? frame_b : frame_a; endfunction
    function automatic logic g_dn(input logic s);  return s ? done_b : done_a; endfunction
    function automatic int   qsize(input logic s); return s ? q_b.size() : q_a.size(); endfunction

    // Monitor and scoreboard for instance a.
    always @(negedge clk) begin
        if (frame_a) frm_cnt[0]++;
        if (done_a) dn_cnt[0]++;
        if (!frame_a) check("sdo_idle_a", 32'(sdo_a), 0);
        if (bit_stb_a) begin
            stb_cnt[0]++;
            if (q_a.size() == 0) check("stb_unexpected_a", 32'(bit_stb_a), 0);
            else check("sdo_bit_a", 32'(sdo_a), 32'(q_a.pop_front()));
        end
    end

    // Monitor and scoreboard for instance b.
    always @(negedge clk) begin
        if (frame_b) frm_cnt[1]++;
        if (done_b) dn_cnt[1]++;
        if (!frame_b) check("sdo_idle_b", 32'(sdo_b), 0);
        if (bit_stb_b) begin
            stb_cnt[1]++;
            if (q_b.size() == 0) check("stb_unexpected_b", 32'(bit_stb_b), 0);
            else check("sdo_bit_b", 32'(sdo_b), 32'(q_b.pop_front()));
        end
    end

    // Wait for ready, present one word, queue its expected bits, and return
    // 1ns after the accepting edge E0 with valid dropped.
    task automatic start_word(input logic s, input logic [19:0] d, input logic [19:0] exp);
        @(negedge clk);
        for (int i = 0; i < 20 && !g_rdy(s); i++) @(negedge clk);
        check("accept_ready", 32'(g_rdy(s)), 1);
        if (s) begin din_b = d; vld_b = 1'b1; end
        else   begin din_a = d; vld_a = 1'b1; end
        for (int k = 19; k >= 0; k--) begin
            if (s) q_b.push_back(exp[k]);
            else   q_a.push_back(exp[k]);
        end
        frm_cnt[int'(s)] = 0;
        stb_cnt[int'(s)] = 0;
        dn_cnt[int'(s)]  = 0;
        @(posedge clk); #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
        check("frame_at_e0", 32'(g_frm(s)), 1);
        check("ready_low_e0", 32'(g_rdy(s)), 0);
    endtask

    task automatic send_word(input logic s, input logic [19:0] d, input logic [19:0] exp, input int len);
        int  i;
        logic seen;
        start_word(s, d, exp);
        seen = 1'b0;
        for (i = 1; i <= len + 10; i++) begin
            @(posedge clk); #1;
            if (g_dn(s)) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 1);
        check("done_latency", 32'(i), 32'(len));
        check("frame_cycles", 32'(frm_cnt[int'(s)]), 32'(len));
        check("stb_count", 32'(stb_cnt[int'(s)]), 20);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(g_dn(s)), 0);
        check("ready_after_done", 32'(g_rdy(s)), 1);
        check("done_pulses", 32'(dn_cnt[int'(s)]), 1);
        check("queue_drained", 32'(qsize(s)), 0);
    endtask

    initial begin
        int t_done, t_rise, low_cnt;
        vecs[0] = '{1'b0, 20'hA5F0C, 20'hA5F0C, 80};
        vecs[1] = '{1'b0, 20'h12345, 20'h12345, 80};
        vecs[2] = '{1'b1, 20'h00003, 20'hC0000, 20};
        vecs[3] = '{1'b1, 20'h12345, 20'hA2C48, 20};
        vecs[4] = '{1'b1, 20'h80000, 20'h00001, 20};

        rst = 1'b1; din_a = 20'hA5F0C; din_b = '0;
        vld_a = 1'b0; vld_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        for (int i = 0; i < 2; i++) begin frm_cnt[i] = 0; stb_cnt[i] = 0; dn_cnt[i] = 0; end
        #2 rst = 1'b0;

        // Reset held with valid high: nothing may come out.
        vld_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", 32'(in_ready_a), 0);
            check("rst_frame", 32'(frame_a), 0);
            check("rst_sdo", 32'(sdo_a), 0);
            check("rst_done", 32'(done_a), 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", 32'(in_ready_a), 1);
        check("no_frame_at_release", 32'(frame_a), 0);
        vld_a = 1'b0;

        // Abort while idle does nothing.
        @(negedge clk); abort_a = 1'b1;
        @(posedge clk); #1; abort_a = 1'b0;
        check("idle_abort_ready", 32'(in_ready_a), 1);
        check("idle_abort_frame", 32'(frame_a), 0);

        // Table-driven single words on both instances.
        foreach (vecs[v]) send_word(vecs[v].sel, vecs[v].data, vecs[v].exp_serial, vecs[v].len);

        // Back-to-back words with valid held high.
        @(negedge clk);
        din_a = 20'h00001; vld_a = 1'b1;
        for (int k = 19; k >= 0; k--) q_a.push_back(1'b0 | (k == 0));
        for (int k = 19; k >= 0; k--) q_a.push_back(1'b1);
        @(posedge clk); #1;
        din_a = 20'hFFFFF;
        t_done = 0; t_rise = 0; low_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done_a && t_done == 0) t_done = i;
            if (t_done > 0 && !frame_a) low_cnt++;
            if (t_done > 0 && frame_a) begin t_rise = i; break; end
        end
        vld_a = 1'b0;
        check("b2b_done_time", 32'(t_done), 80);
        check("b2b_second_accept", 32'(t_rise), 82);
        check("b2b_gap", 32'(low_cnt), 2);
        t_done = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done_a) begin t_done = i; break; end
        end
        check("b2b_second_done", 32'(t_done), 80);
        @(posedge clk); #1;
        check("b2b_queue_drained", 32'(q_a.size()), 0);

        // Abort sampled at E0+37: nine bits sampled, rest discarded.
        start_word(1'b0, 20'h5A5A5, 20'h5A5A5);
        repeat (36) @(posedge clk);
        @(negedge clk); abort_a = 1'b1;
        @(posedge clk); #1; abort_a = 1'b0;
        check("abort_frame", 32'(frame_a), 0);
        check("abort_ready", 32'(in_ready_a), 1);
        check("abort_sdo", 32'(sdo_a), 0);
        check("abort_stb", 32'(bit_stb_a), 0);
        check("abort_bits_sent", 32'(stb_cnt[0]), 9);
        check("abort_queue_left", 32'(q_a.size()), 11);
        q_a.delete();
        repeat (5) @(posedge clk); #1;
        check("abort_no_done", 32'(dn_cnt[0]), 0);
        send_word(1'b0, 20'h12345, 20'h12345, 80);

        // Asynchronous reset during bit 10.
        start_word(1'b0, 20'hABCDE, 20'hABCDE);
        repeat (41) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_frame", 32'(frame_a), 0);
        check("async_sdo", 32'(sdo_a), 0);
        check("async_stb", 32'(bit_stb_a), 0);
        check("async_ready", 32'(in_ready_a), 0);
        repeat (3) @(negedge clk);
        check("async_no_done", 32'(dn_cnt[0]), 0);
        q_a.delete();
        rst = 1'b1;
        send_word(1'b0, 20'h80000, 20'h80000, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_tx20.md
Name: serial_tx20

Overview:
- Parallel-in, serial-out transmitter for 20-bit words.
- Transmit end of the bit-serial link whose receive side captures bits into D-flip-flop registers.
- Accepts a word through a valid/ready handshake and shifts it out at a programmable bit rate.
- Drives a frame qualifier and a per-bit sample strobe so the receiver can capture on a single clock domain.

Parameters:
- WIDTH, 20, bits per word (2..32).
- DIV, 4, clock cycles per serial bit (1..256).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit; sampled on accept.
- in_valid  input  1  word available.
- in_ready  output  1  transmitter can accept a word.
- abort  input  1  synchronous frame cancel.
- sdo  output  1  serial data out.
- frame  output  1  high while bits of a word are on sdo.
- bit_stb  output  1  one-cycle pulse in the last cycle of each bit period (receiver sample point).
- done  output  1  one-cycle pulse after the last bit of a completed word.

Behaviour:
- All outputs are registered.
- rst low clears everything immediately, regardless of clk: state=IDLE, in_ready=0, sdo=0, frame=0, bit_stb=0, done=0, shift register=0, counters=0.
- First rising edge with rst high sets in_ready=1.
- States: IDLE, SHIFT, DONE.
- Accept: an edge where in_valid=1 and in_ready=1 (edge E0).
  - At E0: in_data is loaded, in_ready goes 0, state goes to SHIFT, frame goes 1, sdo takes the first bit, bit_cnt=0, div_cnt=0.
  - in_valid while in_ready=0 is ignored; in_data need not be held after E0.
- SHIFT:
  - div_cnt increments every cycle.
  - bit_stb=1 in the cycle where div_cnt==DIV-1.
  - At that edge, div_cnt wraps to 0 and bit_cnt increments.
  - The shifter advances (left when MSB_FIRST=1, right otherwise) and sdo takes the next bit.
  - Bit k is on sdo from edge E0+k*DIV to E0+(k+1)*DIV.
  - With DIV=1, bit_stb stays high for the whole frame.
- End of word: at edge E0+WIDTH*DIV (wrap with bit_cnt==WIDTH-1):
  - state goes to DONE; frame=0, sdo=0, done=1 for exactly one cycle.
  - Next edge: state goes to IDLE, done=0, in_ready=1.
  - Earliest next accept is edge E0+WIDTH*DIV+2. Back-to-back words have a 2-cycle gap with frame low.
- abort in SHIFT, sampled at an edge:
  - state goes to IDLE, frame=0, sdo=0, bit_stb=0, in_ready=1.
  - done is not pulsed and counters clear.
  - abort has priority over the bit/end-of-word transition at the same edge.
- abort in IDLE or DONE: no effect. In DONE, done still pulses.
- Reset mid-frame: outputs drop asynchronously. No done pulse; the partial word is discarded.
- sdo=0 whenever frame=0.
- Counter widths: div_cnt holds DIV-1; bit_cnt holds WIDTH-1. No overflow beyond those terminal values.

Test Plan:
1. Reset release: hold rst=0 for 3 cycles with in_valid=1 -> in_ready, frame, sdo, done all 0 during reset. in_ready=1 one edge after release; no frame starts before that edge.
2. Single word, WIDTH=20, DIV=4, MSB_FIRST=1, in_data=20'hA5F0C:
   - sdo sequence 1010_0101_1111_0000_1100, each bit held 4 cycles.
   - frame high for 80 cycles; exactly 20 bit_stb pulses.
   - done one cycle at E80; in_ready=1 at E81.
3. Back-to-back: in_valid held high with 20'h00001 then 20'hFFFFF -> second accept at E82. frame low exactly 2 cycles between frames; second frame is twenty 1s.
4. Bit order and rate: MSB_FIRST=0, DIV=1, in_data=20'h00003 -> sdo = 1,1 then eighteen 0s on consecutive cycles; bit_stb high for 20 cycles; done at E20.
5. Abort: assert abort for one cycle at E0+37 (DIV=4) -> frame=0 and in_ready=1 after that edge, no done pulse. Next word 20'h12345 transmits fully and correctly.
6. Async reset mid-frame: drop rst between edges during bit 10 -> frame/sdo/bit_stb go 0 before the next edge, no done pulse. After release, new word 20'h80000 gives sdo=1 then nineteen 0s.
